proc_control_unit: RTL and testbench
====================================

// Module: proc_control_unit
// PURPOSE
//   Instruction-sequencing FSM of the 16-bit processor; the initiator side of the register file.
//   Fetches from a synchronous instruction ROM, decodes each instruction, and drives the
//   register-file write/read addresses, data-memory strobes and ALU select for one instruction at a time.
//   Instruction format: [15:12] opcode, [11:0] operands (below). Holds PC and IR internally.
// PARAMETERS
//   PC_W      8   instruction address width (ROM depth 2**PC_W)
//   DADDR_W   8   data-memory address width; must equal 8 (carried in IR[11:4])
//   RADDR_W   4   register-file address width; must equal 4
// PORTS
//   clk          in   1        system clock, all state on posedge
//   reset        in   1        synchronous, active-high
//   imem_addr    out  PC_W     = pc; ROM data valid one cycle after address
//   imem_rdata   in   16       instruction word
//   dmem_addr    out  DADDR_W  data-memory address (IR[11:4])
//   dmem_wr      out  1        data-memory write strobe
//   rf_wr        out  1        register-file write enable
//   rf_wr_addr   out  RADDR_W  register-file write address
//   rf_rd_addr_a out  RADDR_W  register-file read port A address
//   rf_rd_addr_b out  RADDR_W  register-file read port B address
//   rf_wr_sel    out  1        write-data mux: 0 = ALU result, 1 = dmem read data
//   alu_op       out  2        0 = pass A, 1 = A+B, 2 = A-B, 3 = reserved (pass A)
//   halted       out  1        high while in HALT
//   state_dbg    out  4        current state encoding
// BEHAVIOUR
//   - Opcodes: 0x0 NOOP; 0x1 LOAD  RF[IR[3:0]] <= D[IR[11:4]]; 0x2 STORE D[IR[11:4]] <= RF[IR[3:0]];
//     0x3 ADD RF[IR[3:0]] <= RF[IR[11:8]] + RF[IR[7:4]]; 0x4 SUB (same fields, A-B); 0x5 HALT;
//     all other opcodes execute as NOOP.
//   - States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT (+ JMP, JWAIT w/ macro).
//   - INIT -> FETCH: pc held at 0 one cycle so ROM output is valid in FETCH.
//   - FETCH: ir <= imem_rdata, pc <= pc+1 (wraps 2**PC_W-1 -> 0); -> DECODE.
//   - DECODE: no strobes; -> opcode state. NOOP/STORE/ADD/SUB/LOAD_B -> FETCH; LOAD_A -> LOAD_B.
//   - LOAD_A: dmem_addr valid, no writes; LOAD_B: rf_wr=1, rf_wr_sel=1, rf_wr_addr=IR[3:0].
//   - STORE: dmem_wr=1, rf_rd_addr_a=IR[3:0]. ADD/SUB: rf_wr=1, rf_wr_sel=0, alu_op=1/2.
//   - Latency: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4 cycles, fetch edge to fetch edge.
//   - HALT: absorbing; halted=1, all strobes 0, pc frozen; only reset exits.
//   - Outputs decoded combinationally from state+IR; address outputs always reflect IR fields.
//   - Reset: state=INIT, pc=0, ir=0; rf_wr, dmem_wr, halted = 0; alu_op=0; rf_wr_sel=0.
//   - rf_wr and dmem_wr gated by !reset: reset asserted mid-instruction never commits a write
//     on that edge; in-flight LOAD/STORE is abandoned.
//   - No ALU overflow/carry handling; 16-bit arithmetic wraps (datapath concern).
// CONFIGURATION
//   CU_JUMP_EN defined: opcode 0x6 JMP, pc <= IR[PC_W-1:0] in JMP, then JWAIT (one idle cycle for
//     ROM latency), then FETCH; 4 cycles total, no strobes.
//   CU_JUMP_EN undefined: 0x6 executes as NOOP; JMP/JWAIT states absent.
// STRUCTURE
//   cu_pkg: opcode_t enum, state_t enum (4-bit, fixed encodings for state_dbg), ALU_PASS/ADD/SUB
//     localparams.
//   One sub-module: cu_fetch (pc counter with clear/increment/load, IR register with load).
//   Top holds the FSM and output decode.
// TESTING
//   1. Reset then ROM[0]=0x5000 -> INIT,FETCH,DECODE,HALT; halted=1 on cycle 4 and stays; pc=1.
//   2. ROM[0]=0x3123 (ADD) -> in ADD: rd_a=1, rd_b=2, rf_wr_addr=3, alu_op=1, rf_wr=1 for one cycle.
//   3. ROM[0]=0x11A5 (LOAD) -> dmem_addr=0x1A; rf_wr=1, rf_wr_sel=1, rf_wr_addr=5 only in LOAD_B.
//   4. ROM[0]=0x2334 (STORE) with reset asserted during STORE -> dmem_wr stays 0; next state INIT, pc=0.
//   5. pc=0xFF, ROM[0xFF]=0x0000 -> after FETCH pc=0x00; opcode 0xE behaves as NOOP.
//   6. CU_JUMP_EN: ROM[0]=0x6040 -> JMP,JWAIT then FETCH with imem_addr=0x40; without macro pc=1.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types for the processor control unit: opcodes, FSM state encodings, ALU selects.
// The CU_JUMP_EN macro adds the JMP opcode and the JMP/JWAIT states.
package cu_pkg;

  localparam int IR_W = 16;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5,
    OP_JMP   = 4'h6
  } opcode_t;

  // Encodings are fixed because they are visible on state_dbg.
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
`ifdef CU_JUMP_EN
    ,
    S_JMP    = 4'd10,
    S_JWAIT  = 4'd11
`endif
  } state_t;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;

  // Execute state entered from DECODE; unknown opcodes fall through to NOOP.
  function automatic state_t decode_next(input logic [3:0] op);
    state_t nxt;
    nxt = S_NOOP;
    case (op)
      OP_LOAD:  nxt = S_LOAD_A;
      OP_STORE: nxt = S_STORE;
      OP_ADD:   nxt = S_ADD;
      OP_SUB:   nxt = S_SUB;
      OP_HALT:  nxt = S_HALT;
`ifdef CU_JUMP_EN
      OP_JMP:   nxt = S_JMP;
`endif
      default:  nxt = S_NOOP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cu_fetch.sv
// Program counter (clear / load / increment, wrapping) and instruction register.
module cu_fetch
  import cu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcClear,
  input  logic            pcInc,
  input  logic            pcLoad,
  input  logic [PC_W-1:0] pcLoadVal,
  input  logic            irLoad,
  input  logic [IR_W-1:0] irIn,
  output logic [PC_W-1:0] pc,
  output logic [IR_W-1:0] ir
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (pcClear)     pc <= '0;
      else if (pcLoad) pc <= pcLoadVal;
      else if (pcInc)  pc <= pc + PC_W'(1);
      if (irLoad) ir <= irIn;
    end
  end

endmodule

// File: rtl/proc_control_unit.sv
// Instruction-sequencing FSM of the 16-bit processor: fetch, decode, drive RF/dmem/ALU controls.
// Define CU_JUMP_EN to enable the JMP opcode (0x6) with its JMP/JWAIT states.
module proc_control_unit
  import cu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_wr,
  output logic               rf_wr,
  output logic [RADDR_W-1:0] rf_wr_addr,
  output logic [RADDR_W-1:0] rf_rd_addr_a,
  output logic [RADDR_W-1:0] rf_rd_addr_b,
  output logic               rf_wr_sel,
  output logic [1:0]         alu_op,
  output logic               halted,
  output logic [3:0]         state_dbg
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            pcClear;
  logic            pcInc;
  logic            pcLoad;
  logic            irLoad;

  always_comb begin
    pcClear = (state == S_INIT);
    pcInc   = (state == S_FETCH);
    irLoad  = (state == S_FETCH);
`ifdef CU_JUMP_EN
    pcLoad  = (state == S_JMP);
`else
    pcLoad  = 1'b0;
`endif
  end

  cu_fetch #(.PC_W(PC_W)) u_fetch (
    .clk       (clk),
    .reset     (reset),
    .pcClear   (pcClear),
    .pcInc     (pcInc),
    .pcLoad    (pcLoad),
    .pcLoadVal (ir[PC_W-1:0]),
    .irLoad    (irLoad),
    .irIn      (imem_rdata),
    .pc        (pc),
    .ir        (ir)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= decode_next(ir[15:12]);
        S_LOAD_A: state <= S_LOAD_B;
        S_HALT:   state <= S_HALT;
`ifdef CU_JUMP_EN
        S_JMP:    state <= S_JWAIT;
        S_JWAIT:  state <= S_FETCH;
`endif
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Write strobes are masked by reset so an in-flight instruction never commits on a reset edge.
  always_comb begin
    imem_addr    = pc;
    dmem_addr    = ir[11:4];
    rf_wr_addr   = ir[3:0];
    rf_rd_addr_a = (state == S_STORE) ? ir[3:0] : ir[11:8];
    rf_rd_addr_b = ir[7:4];
    rf_wr        = !reset && (state == S_LOAD_B || state == S_ADD || state == S_SUB);
    dmem_wr      = !reset && (state == S_STORE);
    rf_wr_sel    = (state == S_LOAD_B);
    alu_op       = ALU_PASS;
    if (state == S_ADD) alu_op = ALU_ADD;
    if (state == S_SUB) alu_op = ALU_SUB;
    halted       = (state == S_HALT);
    state_dbg    = state;
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: directed scenarios plus random programs against an ISA model.
module tb_proc_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [7:0]  dmem_addr;
  logic        dmem_wr;
  logic        rf_wr;
  logic [3:0]  rf_wr_addr;
  logic [3:0]  rf_rd_addr_a;
  logic [3:0]  rf_rd_addr_b;
  logic        rf_wr_sel;
  logic [1:0]  alu_op;
  logic        halted;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .dmem_addr    (dmem_addr),
    .dmem_wr      (dmem_wr),
    .rf_wr        (rf_wr),
    .rf_wr_addr   (rf_wr_addr),
    .rf_rd_addr_a (rf_rd_addr_a),
    .rf_rd_addr_b (rf_rd_addr_b),
    .rf_wr_sel    (rf_wr_sel),
    .alu_op       (alu_op),
    .halted       (halted),
    .state_dbg    (state_dbg)
  );

  // Synchronous instruction ROM
  logic [15:0] rom [256];
  logic [15:0] rom_q;
  always @(posedge clk) rom_q <= rom[imem_addr];
  assign imem_rdata = rom_q;

  // Datapath that obeys the DUT's strobes
  logic [15:0] rf [16];
  logic [15:0] dm [256];
  logic [15:0] rf_init [16];
  logic [15:0] dm_init [256];
  logic        dp_init = 1'b0;
  logic [15:0] alu_res;

  always_comb begin
    case (alu_op)
      2'd1:    alu_res = rf[rf_rd_addr_a] + rf[rf_rd_addr_b];
      2'd2:    alu_res = rf[rf_rd_addr_a] - rf[rf_rd_addr_b];
      default: alu_res = rf[rf_rd_addr_a];
    endcase
  end

  always @(posedge clk) begin
    if (dp_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
      for (int i = 0; i < 256; i++) dm[i] <= dm_init[i];
    end else begin
      if (rf_wr) rf[rf_wr_addr] <= rf_wr_sel ? dm[dmem_addr] : alu_res;
      if (dmem_wr) dm[dmem_addr] <= rf[rf_rd_addr_a];
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 16; i++) rf_init[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) dm_init[i] = 16'($urandom);
  endtask

  // Leaves the bench at a negedge with reset released and the DUT in INIT.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    dp_init = 1'b1;
    step();
    step();
    dp_init = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc got %0h exp 0", imem_addr); end
    checks++; if ({rf_wr, dmem_wr, halted, rf_wr_sel, alu_op} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 000000", {rf_wr, dmem_wr, halted, rf_wr_sel, alu_op});
    end
    reset = 1'b0;
  endtask

  task automatic test_halt();
    int exp_st[7] = '{0, 1, 2, 9, 9, 9, 9};
    fill_rom(16'h0000);
    rom[0] = 16'h5000;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      checks++; if (state_dbg !== 4'(exp_st[c])) begin errors++; $display("FAIL halt_state c%0d got %0d exp %0d", c, state_dbg, exp_st[c]); end
      checks++; if (halted !== (c >= 3)) begin errors++; $display("FAIL halt_flag c%0d got %b exp %b", c, halted, c >= 3); end
      checks++; if (c >= 3 && (rf_wr | dmem_wr) !== 1'b0) begin errors++; $display("FAIL halt_strobes c%0d got %b exp 0", c, rf_wr | dmem_wr); end
      step();
    end
    checks++; if (imem_addr !== 8'h01) begin errors++; $display("FAIL halt_pc got %0h exp 1", imem_addr); end
  endtask

  task automatic test_add();
    int wr_cnt;
    logic [15:0] exp_sum;
    randomize_data();
    fill_rom(16'h5000);
    rom[0] = 16'h3123;
    exp_sum = rf_init[1] + rf_init[2];
    apply_reset();
    step(); step(); step();
    checks++; if (state_dbg !== 4'd7) begin errors++; $display("FAIL add_state got %0d exp 7", state_dbg); end
    checks++; if ({rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr} !== 12'h123) begin
      errors++; $display("FAIL add_addrs got %0h exp 123", {rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr});
    end
    checks++; if ({alu_op, rf_wr, rf_wr_sel} !== 4'b0110) begin
      errors++; $display("FAIL add_ctrl got %b exp 0110", {alu_op, rf_wr, rf_wr_sel});
    end
    wr_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rf_wr) wr_cnt++;
    end
    checks++; if (wr_cnt != 0) begin errors++; $display("FAIL add_one_shot got %0d extra writes exp 0", wr_cnt); end
    checks++; if (rf[3] !== exp_sum) begin errors++; $display("FAIL add_result got %0h exp %0h", rf[3], exp_sum); end
  endtask

  task automatic test_load();
    int exp_st[8] = '{0, 1, 2, 4, 5, 1, 2, 9};
    randomize_data();
    fill_rom(16'h5000);
    rom[0] = 16'h11A5;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      checks++; if (state_dbg !== 4'(exp_st[c])) begin errors++; $display("FAIL load_state c%0d got %0d exp %0d", c, state_dbg, exp_st[c]); end
      checks++; if (rf_wr !== (c == 4) || dmem_wr !== 1'b0) begin
        errors++; $display("FAIL load_strobes c%0d got rf_wr=%b dmem_wr=%b exp rf_wr=%b", c, rf_wr, dmem_wr, c == 4);
      end
      if (c >= 3 && c <= 4) begin
        checks++; if (dmem_addr !== 8'h1A) begin errors++; $display("FAIL load_daddr c%0d got %0h exp 1a", c, dmem_addr); end
      end
      if (c == 4) begin
        checks++; if (rf_wr_sel !== 1'b1 || rf_wr_addr !== 4'h5) begin
          errors++; $display("FAIL load_b got sel=%b addr=%0h exp sel=1 addr=5", rf_wr_sel, rf_wr_addr);
        end
      end
      step();
    end
    checks++; if (rf[5] !== dm_init[8'h1A]) begin errors++; $display("FAIL load_result got %0h exp %0h", rf[5], dm_init[8'h1A]); end
  endtask

  task automatic test_store_reset();
    randomize_data();
    rf_init[4] = ~dm_init[8'h33];
    fill_rom(16'h5000);
    rom[0] = 16'h2334;
    apply_reset();
    step(); step(); step();
    checks++; if (state_dbg !== 4'd6 || dmem_wr !== 1'b1 || rf_rd_addr_a !== 4'h4) begin
      errors++; $display("FAIL store_ctrl got st=%0d wr=%b rda=%0h exp st=6 wr=1 rda=4", state_dbg, dmem_wr, rf_rd_addr_a);
    end
    reset = 1'b1;
    #1;
    checks++; if (dmem_wr !== 1'b0) begin errors++; $display("FAIL store_reset_gate got %b exp 0", dmem_wr); end
    step();
    checks++; if (state_dbg !== 4'd0 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL store_reset_next got st=%0d pc=%0h exp st=0 pc=0", state_dbg, imem_addr);
    end
    checks++; if (dm[8'h33] !== dm_init[8'h33]) begin errors++; $display("FAIL store_no_commit got %0h exp %0h", dm[8'h33], dm_init[8'h33]); end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    int edges;
    fill_rom(16'hE000);
    rom[8'hFF] = 16'h0000;
    apply_reset();
    step(); step();
    edges = 2;
    checks++; if (state_dbg !== 4'd2) begin errors++; $display("FAIL wrap_decode got %0d exp 2", state_dbg); end
    step();
    edges++;
    checks++; if (state_dbg !== 4'd3) begin errors++; $display("FAIL wrap_op_e_noop got %0d exp 3", state_dbg); end
    while (!(state_dbg == 4'd1 && imem_addr == 8'hFF) && edges < 1000) begin
      step();
      edges++;
    end
    checks++; if (edges != 766) begin errors++; $display("FAIL wrap_reach_ff got %0d edges exp 766", edges); end
    step();
    checks++; if (imem_addr !== 8'h00 || state_dbg !== 4'd2) begin
      errors++; $display("FAIL wrap_pc got pc=%0h st=%0d exp pc=0 st=2", imem_addr, state_dbg);
    end
  endtask

  task automatic test_jump();
    fill_rom(16'h5000);
    rom[0] = 16'h6040;
    apply_reset();
    step(); step(); step();
`ifdef CU_JUMP_EN
    checks++; if (state_dbg !== 4'd10) begin errors++; $display("FAIL jmp_state got %0d exp 10", state_dbg); end
    step();
    checks++; if (state_dbg !== 4'd11 || imem_addr !== 8'h40) begin
      errors++; $display("FAIL jwait got st=%0d pc=%0h exp st=11 pc=40", state_dbg, imem_addr);
    end
    step();
    checks++; if (state_dbg !== 4'd1 || imem_addr !== 8'h40 || rom_q !== rom[8'h40]) begin
      errors++; $display("FAIL jmp_fetch got st=%0d pc=%0h exp st=1 pc=40", state_dbg, imem_addr);
    end
`else
    checks++; if (state_dbg !== 4'd3) begin errors++; $display("FAIL op6_noop got %0d exp 3", state_dbg); end
    step();
    checks++; if (state_dbg !== 4'd1 || imem_addr !== 8'h01) begin
      errors++; $display("FAIL op6_fetch got st=%0d pc=%0h exp st=1 pc=1", state_dbg, imem_addr);
    end
`endif
  endtask

  // Architectural model: run the program instruction by instruction, summing documented latencies.
  task automatic test_random_programs();
    logic [15:0] mrf [16];
    logic [15:0] mdm [256];
    logic [15:0] ins;
    logic [7:0]  mpc;
    int n, v, exp_edges, edges;
    bit done;
    for (int p = 0; p < 4; p++) begin
      randomize_data();
      fill_rom(16'h5000);
      n = $urandom_range(10, 30);
      for (int i = 0; i < n; i++) begin
        v = $urandom_range(0, 13);
        if (v >= 5) v = v + 2;
        rom[i] = {4'(v), 12'($urandom)};
      end
      for (int i = 0; i < 16; i++) mrf[i] = rf_init[i];
      for (int i = 0; i < 256; i++) mdm[i] = dm_init[i];
      mpc = 8'h00;
      exp_edges = 1;
      done = 1'b0;
      while (!done) begin
        ins = rom[mpc];
        mpc = mpc + 8'd1;
        case (ins[15:12])
          4'h1: begin mrf[ins[3:0]] = mdm[ins[11:4]]; exp_edges += 4; end
          4'h2: begin mdm[ins[11:4]] = mrf[ins[3:0]]; exp_edges += 3; end
          4'h3: begin mrf[ins[3:0]] = mrf[ins[11:8]] + mrf[ins[7:4]]; exp_edges += 3; end
          4'h4: begin mrf[ins[3:0]] = mrf[ins[11:8]] - mrf[ins[7:4]]; exp_edges += 3; end
          4'h5: begin exp_edges += 2; done = 1'b1; end
          default: exp_edges += 3;
        endcase
      end
      apply_reset();
      edges = 0;
      while (!halted && edges < 500) begin
        step();
        edges++;
      end
      checks++; if (edges != exp_edges) begin errors++; $display("FAIL rand%0d_halt_cycle got %0d exp %0d", p, edges, exp_edges); end
      checks++; if (imem_addr !== mpc) begin errors++; $display("FAIL rand%0d_halt_pc got %0h exp %0h", p, imem_addr, mpc); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (rf[i] !== mrf[i]) begin errors++; $display("FAIL rand%0d_rf%0d got %0h exp %0h", p, i, rf[i], mrf[i]); end
      end
      for (int i = 0; i < 256; i++) begin
        checks++; if (dm[i] !== mdm[i]) begin errors++; $display("FAIL rand%0d_dm%0h got %0h exp %0h", p, i, dm[i], mdm[i]); end
      end
    end
  endtask

  initial begin
    fill_rom(16'h0000);
    randomize_data();
    test_reset();
    test_halt();
    test_add();
    test_load();
    test_store_reset();
    test_wrap();
    test_jump();
    test_random_programs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
